// File: rtl/vx_launch_pkg.sv
// vx_launch_pkg: shared state encoding, status codes and default parameters
// for the Vortex launch controller.
package vx_launch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_WAIT_BUSY,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] STAT_OK     = 2'd0;
  localparam logic [1:0] STAT_NOBUSY = 2'd1;
  localparam logic [1:0] STAT_ABORT  = 2'd2;
  localparam logic [1:0] STAT_WDT    = 2'd3;

  localparam int DEF_RST_CYCLES   = 8;
  localparam int DEF_BUSY_TIMEOUT = 1024;
  localparam int DEF_CNT_WIDTH    = 32;
  localparam int DEF_OUTST_WIDTH  = 8;
  localparam int DEF_WDT_CYCLES   = 2**24;

endpackage

// File: rtl/vx_outst_counter.sv
// vx_outst_counter: saturating inc/dec outstanding-transaction counter
// with synchronous clear and a zero flag.
module vx_outst_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Simultaneous inc/dec nets to zero; both ends saturate instead of wrapping.
  always_comb begin
    cnt_d = clr_i                                   ? '0 :
            (inc_i && !dec_i && cnt_q != '1)        ? cnt_q + WIDTH'(1) :
            (dec_i && !inc_i && cnt_q != '0)        ? cnt_q - WIDTH'(1) :
                                                      cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vortex_launch_ctrl.sv
// vortex_launch_ctrl: run sequencer for the Vortex core (reset hold, busy wait,
// AXI drain, completion irq). Optional watchdog enabled by VX_LAUNCH_WDT_EN.
module vortex_launch_ctrl
  import vx_launch_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int OUTST_WIDTH  = DEF_OUTST_WIDTH
`ifdef VX_LAUNCH_WDT_EN
  , parameter int WDT_CYCLES = DEF_WDT_CYCLES
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 irq_ack,
  input  logic                 vx_busy,
  input  logic                 aw_fire,
  input  logic                 b_fire,
  input  logic                 ar_fire,
  input  logic                 rlast_fire,
  output logic                 vx_reset,
  output logic                 running,
  output logic                 done,
  output logic                 irq,
  output logic [1:0]           status,
  output logic [CNT_WIDTH-1:0] cycles
);

  localparam int TMAX = (RST_CYCLES > BUSY_TIMEOUT) ? RST_CYCLES : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tmr_q;
  logic [CNT_WIDTH-1:0] cycles_q;
  logic [1:0]           status_q, status_d;
  logic                 vx_reset_q, vx_reset_d, running_q, done_q, irq_q;
  logic                 run_st, act_st, tmr_st, cnt_clr, wdt_hit;
  logic [OUTST_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                 wr_zero, rd_zero;

  assign run_st = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign act_st = state_q inside {S_RST_HOLD, S_WAIT_BUSY, S_RUN, S_DRAIN};
  assign tmr_st = (state_q == S_RST_HOLD) || (state_q == S_WAIT_BUSY);

`ifdef VX_LAUNCH_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_q;
  assign wdt_hit = run_st && (wdt_q == WW'(WDT_CYCLES - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wdt_q <= '0;
    else        wdt_q <= (run_st && (state_d == S_RUN || state_d == S_DRAIN)) ? wdt_q + WW'(1) : '0;
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    case (state_q)
      S_IDLE:      if (start) begin
                     state_d  = S_RST_HOLD;
                     status_d = STAT_OK;
                   end
      S_RST_HOLD:  if (tmr_q == TW'(RST_CYCLES - 1)) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (vx_busy) state_d = S_RUN;
                   else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
                     state_d  = S_DONE;
                     status_d = STAT_NOBUSY;
                   end
      S_RUN:       if (!vx_busy) state_d = S_DRAIN;
      S_DRAIN:     if (vx_busy) state_d = S_RUN;
                   else if (wr_zero && rd_zero) state_d = S_DONE;
      S_DONE:      if (irq_ack) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (wdt_hit) begin
      state_d  = S_DONE;
      status_d = STAT_WDT;
    end
    // Abort is evaluated last so it overrides every other exit, watchdog included.
    if (abort && act_st) begin
      state_d  = S_DONE;
      status_d = STAT_ABORT;
    end
  end

  assign vx_reset_d = !(state_d inside {S_WAIT_BUSY, S_RUN, S_DRAIN});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      cycles_q   <= '0;
      status_q   <= STAT_OK;
      vx_reset_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      tmr_q      <= (tmr_st && state_d == state_q) ? tmr_q + TW'(1) : '0;
      cycles_q   <= (state_q == S_IDLE && start) ? '0 :
                    (run_st && cycles_q != '1)  ? cycles_q + CNT_WIDTH'(1) : cycles_q;
      vx_reset_q <= vx_reset_d;
      running_q  <= state_d inside {S_RST_HOLD, S_WAIT_BUSY, S_RUN, S_DRAIN};
      done_q     <= (state_d == S_DONE);
      irq_q      <= (state_d == S_DONE);
    end
  end

  // Clearing on either edge of vx_reset drops fires seen while the core is held
  // and empties the counters in the same cycle DONE is entered.
  assign cnt_clr = vx_reset_q | vx_reset_d;

  vx_outst_counter #(.WIDTH(OUTST_WIDTH)) u_wr (
    .clk(clk), .rst_n(reset), .clr_i(cnt_clr), .inc_i(aw_fire), .dec_i(b_fire),
    .cnt_o(wr_cnt), .zero_o(wr_zero)
  );

  vx_outst_counter #(.WIDTH(OUTST_WIDTH)) u_rd (
    .clk(clk), .rst_n(reset), .clr_i(cnt_clr), .inc_i(ar_fire), .dec_i(rlast_fire),
    .cnt_o(rd_cnt), .zero_o(rd_zero)
  );

  assign vx_reset = vx_reset_q;
  assign running  = running_q;
  assign done     = done_q;
  assign irq      = irq_q;
  assign status   = status_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_vortex_launch_ctrl.sv
// tb_vortex_launch_ctrl: table/scoreboard bench for vortex_launch_ctrl
// (watchdog case only built with VX_LAUNCH_WDT_EN).
module tb_vortex_launch_ctrl;
  import vx_launch_pkg::*;

  localparam int RC = 8;
  localparam int BT = 16;
`ifdef VX_LAUNCH_WDT_EN
  localparam int NOM_BUSY = 40;
`else
  localparam int NOM_BUSY = 100;
`endif

  logic clk = 0, reset = 0, start = 0, abort = 0, irq_ack = 0, vx_busy = 0;
  logic aw_fire = 0, b_fire = 0, ar_fire = 0, rlast_fire = 0;
  logic vx_reset, running, done, irq;
  logic [1:0] status;
  logic [31:0] cycles;
  int n_tot = 0, n_pass = 0;

  typedef struct {
    logic busy, aw, b, ar, rl;
    int   wr, rd;
    logic run, dn;
  } vec_t;
  vec_t vecs[9];
  vec_t exp_q[$];
  vec_t e;

  vortex_launch_ctrl #(
    .RST_CYCLES(RC), .BUSY_TIMEOUT(BT), .CNT_WIDTH(32), .OUTST_WIDTH(8)
`ifdef VX_LAUNCH_WDT_EN
    , .WDT_CYCLES(64)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .irq_ack(irq_ack),
    .vx_busy(vx_busy), .aw_fire(aw_fire), .b_fire(b_fire), .ar_fire(ar_fire),
    .rlast_fire(rlast_fire), .vx_reset(vx_reset), .running(running), .done(done),
    .irq(irq), .status(status), .cycles(cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic launch(input logic with_abort);
    start = 1; abort = with_abort;
    tick();
    start = 0; abort = 0;
    chk("hold_running", running, 1);
    chk("hold_status_cleared", status, STAT_OK);
    repeat (RC - 1) tick();
    chk("hold_vx_reset_last", vx_reset, 1);
    tick();
    chk("release_vx_reset", vx_reset, 0);
  endtask

  initial begin
    //           busy aw b ar rl  wr rd run dn
    vecs[0] = '{1, 0, 1, 0, 1,  0, 0, 1, 0};
    vecs[1] = '{1, 1, 0, 0, 0,  1, 0, 1, 0};
    vecs[2] = '{1, 1, 1, 0, 0,  1, 0, 1, 0};
    vecs[3] = '{1, 1, 0, 1, 0,  2, 1, 1, 0};
    vecs[4] = '{1, 0, 0, 1, 0,  2, 2, 1, 0};
    vecs[5] = '{1, 0, 1, 0, 0,  1, 2, 1, 0};
    vecs[6] = '{1, 0, 0, 0, 1,  1, 1, 1, 0};
    vecs[7] = '{1, 0, 0, 1, 1,  1, 1, 1, 0};
    vecs[8] = '{0, 0, 0, 0, 0,  1, 1, 1, 0};

    #12;
    chk("rst_vx_reset", vx_reset, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_status", status, 0);
    chk("rst_cycles", cycles, 0);
    reset = 1;
    tick();

    // Nominal run
    launch(0);
    vx_busy = 1;
    repeat (NOM_BUSY) tick();
    vx_busy = 0;
    tick();
    chk("nom_drain_done", done, 0);
    tick();
    chk("nom_done", done, 1);
    chk("nom_irq", irq, 1);
    chk("nom_vx_reset", vx_reset, 1);
    chk("nom_status", status, STAT_OK);
    chk("nom_cycles", cycles, NOM_BUSY + 1);
    start = 1;
    tick();
    start = 0;
    chk("done_ignores_start", done, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("ack_irq", irq, 0);
    chk("ack_done", done, 0);
    chk("ack_keeps_cycles", cycles, NOM_BUSY + 1);

    // Drain wait, table driven through the scoreboard
    launch(0);
    vx_busy = 1;
    tick();
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      {vx_busy, aw_fire, b_fire, ar_fire, rlast_fire} =
        {vecs[i].busy, vecs[i].aw, vecs[i].b, vecs[i].ar, vecs[i].rl};
      tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_wr", i), dut.wr_cnt, e.wr);
      chk($sformatf("vec%0d_rd", i), dut.rd_cnt, e.rd);
      chk($sformatf("vec%0d_running", i), running, e.run);
      chk($sformatf("vec%0d_done", i), done, e.dn);
    end
    repeat (19) tick();
    chk("drain_pending_done", done, 0);
    b_fire = 1; rlast_fire = 1;
    tick();
    b_fire = 0; rlast_fire = 0;
    chk("drain_wr_zero", dut.wr_cnt, 0);
    chk("drain_rd_zero", dut.rd_cnt, 0);
    chk("drain_last_resp_done", done, 0);
    tick();
    chk("drain_done", done, 1);
    chk("drain_status", status, STAT_OK);
    irq_ack = 1; tick(); irq_ack = 0;

    // No-busy timeout
    launch(0);
    repeat (BT - 1) tick();
    chk("to_before_done", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_status", status, STAT_NOBUSY);
    chk("to_vx_reset", vx_reset, 1);
    irq_ack = 1; tick(); irq_ack = 0;

    // Abort with writes outstanding
    launch(0);
    vx_busy = 1;
    tick();
    aw_fire = 1;
    repeat (2) tick();
    aw_fire = 0;
    chk("abort_wr_pending", dut.wr_cnt, 2);
    abort = 1;
    tick();
    abort = 0;
    vx_busy = 0;
    chk("abort_done", done, 1);
    chk("abort_status", status, STAT_ABORT);
    chk("abort_vx_reset", vx_reset, 1);
    chk("abort_wr_cleared", dut.wr_cnt, 0);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("abort_ack_irq", irq, 0);
    chk("abort_ack_status_kept", status, STAT_ABORT);
    abort = 1; tick(); abort = 0;
    chk("idle_abort_ignored", running, 0);
    chk("idle_abort_no_done", done, 0);

    // Start beats abort in IDLE; fires ignored while core is held
    aw_fire = 1;
    launch(1);
    aw_fire = 0;
    chk("held_fire_ignored", dut.wr_cnt, 0);
    vx_busy = 1; tick();
    aw_fire = 1; tick();
    aw_fire = 0; vx_busy = 0; tick();
    chk("pre_async_running", running, 1);
    #3 reset = 0;
    #1;
    chk("async_vx_reset", vx_reset, 1);
    chk("async_running", running, 0);
    chk("async_cycles", cycles, 0);
    chk("async_wr", dut.wr_cnt, 0);
    #2 reset = 1;
    tick();

`ifdef VX_LAUNCH_WDT_EN
    launch(0);
    vx_busy = 1;
    tick();
    repeat (63) tick();
    chk("wdt_before", done, 0);
    tick();
    chk("wdt_done", done, 1);
    chk("wdt_status", status, STAT_WDT);
    chk("wdt_vx_reset", vx_reset, 1);
    vx_busy = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
